// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for RV32 stage-boundary pipeline registers: entry-count states,
// the canonical NOP instruction and the packed payload field layout.
package rv32_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [31:0] RV32_NOP_INSN = 32'h0000_0013;

  // Default 160-bit payload: {ctrl, rs1, rs2, pc, imm}, LSB first.
  localparam int PL_IMM_LSB  = 0;
  localparam int PL_PC_LSB   = 32;
  localparam int PL_RS2_LSB  = 64;
  localparam int PL_RS1_LSB  = 96;
  localparam int PL_CTRL_LSB = 128;
  localparam int PL_FIELD_W  = 32;
  localparam int PL_W        = 160;

  function automatic logic [PL_FIELD_W-1:0] pl_field(input logic [PL_W-1:0] pl, input int lsb);
    return pl[lsb +: PL_FIELD_W];
  endfunction

endpackage

// File: rtl/rv32_pipe_skid_buf.sv
// Second entry and entry-count FSM of the elastic stage register (used under RV32_PIPE_SKID_EN).
// up_ready_out is a flop, so the upstream stall path never sees down_ready_in.
module rv32_pipe_skid_buf
  import rv32_pipe_pkg::*;
#(
  parameter int                 DATA_W      = 160,
  parameter logic [DATA_W-1:0]  NOP_PAYLOAD = '0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              flush_in,
  input  logic              up_fire_in,
  input  logic              down_fire_in,
  input  logic [DATA_W-1:0] up_data_in,
  output pipe_state_e       state_out,
  output logic [DATA_W-1:0] skid_data_out,
  output logic              up_ready_out
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_rdy_q, up_rdy_d;

  always_comb begin
    state_d = state_q;
    skid_d  = skid_q;
    if (flush_in) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (up_fire_in) state_d = ST_ONE;
        ST_ONE: begin
          if (up_fire_in && !down_fire_in) begin
            state_d = ST_TWO;
            skid_d  = up_data_in;
          end else if (down_fire_in && !up_fire_in) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO:   if (down_fire_in) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
    up_rdy_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q  <= ST_EMPTY;
      skid_q   <= NOP_PAYLOAD;
      up_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      skid_q   <= skid_d;
      up_rdy_q <= up_rdy_d;
    end
  end

  assign state_out     = state_q;
  assign skid_data_out = skid_q;
  assign up_ready_out  = up_rdy_q;

endmodule

// File: rtl/rv32_pipe_stage_reg.sv
// Elastic RV32 stage register: 1-cycle latency, FIFO order, flush/bubble qualified output.
// RV32_PIPE_SKID_EN adds a skid entry and registers up_ready_out; otherwise ready is combinational.
module rv32_pipe_stage_reg
  import rv32_pipe_pkg::*;
#(
  parameter int                 DATA_W      = 160,
  parameter logic [DATA_W-1:0]  NOP_PAYLOAD = {DATA_W{1'b0}}
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              up_valid_in,
  output logic              up_ready_out,
  input  logic [DATA_W-1:0] up_data_in,
  output logic              down_valid_out,
  input  logic              down_ready_in,
  output logic [DATA_W-1:0] down_data_out,
  input  logic              flush_in,
  input  logic              bubble_in,
  output logic [1:0]        occupancy_out
);

  logic              up_fire, down_fire, head_vld;
  logic [DATA_W-1:0] head_dat_q, head_dat_d;

  assign down_valid_out = head_vld & ~bubble_in;
  assign down_data_out  = down_valid_out ? head_dat_q : NOP_PAYLOAD;
  assign up_fire        = up_valid_in & up_ready_out;
  assign down_fire      = down_valid_out & down_ready_in;

`ifdef RV32_PIPE_SKID_EN
  pipe_state_e       state;
  logic [DATA_W-1:0] skid_dat;

  rv32_pipe_skid_buf #(
    .DATA_W      (DATA_W),
    .NOP_PAYLOAD (NOP_PAYLOAD)
  ) u_skid (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .up_fire_in    (up_fire),
    .down_fire_in  (down_fire),
    .up_data_in    (up_data_in),
    .state_out     (state),
    .skid_data_out (skid_dat),
    .up_ready_out  (up_ready_out)
  );

  assign head_vld      = (state != ST_EMPTY);
  assign occupancy_out = state;

  // Head takes the skid entry when draining from TWO, else the incoming payload
  // whenever the head slot is free or being vacated this cycle.
  always_comb begin
    head_dat_d = head_dat_q;
    if (!flush_in) begin
      if (state == ST_TWO) begin
        if (down_fire) head_dat_d = skid_dat;
      end else if (up_fire && (state == ST_EMPTY || down_fire)) begin
        head_dat_d = up_data_in;
      end
    end
  end
`else
  pipe_state_e state_q, state_d;

  assign head_vld      = (state_q != ST_EMPTY);
  assign up_ready_out  = ~head_vld | (down_ready_in & ~bubble_in);
  assign occupancy_out = {1'b0, head_vld};

  always_comb begin
    state_d    = state_q;
    head_dat_d = head_dat_q;
    if (flush_in) begin
      state_d = ST_EMPTY;
    end else if (up_fire) begin
      state_d    = ST_ONE;
      head_dat_d = up_data_in;
    end else if (down_fire) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) state_q <= ST_EMPTY;
    else           state_q <= state_d;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_in) head_dat_q <= NOP_PAYLOAD;
    else           head_dat_q <= head_dat_d;
  end

endmodule

// File: tb/tb_rv32_pipe_stage_reg.sv
// Randomised bench for rv32_pipe_stage_reg against a queue model; builds with or without RV32_PIPE_SKID_EN.
module tb_rv32_pipe_stage_reg;

  localparam int             DW  = 160;
  localparam logic [DW-1:0]  NOP = 160'h13;
`ifdef RV32_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk_in = 1'b0;
  logic          reset_in, up_valid_in, up_ready_out, down_valid_out, down_ready_in;
  logic          flush_in, bubble_in;
  logic [DW-1:0] up_data_in, down_data_out;
  logic [1:0]    occupancy_out;

  always #5 clk_in = ~clk_in;

  rv32_pipe_stage_reg #(.DATA_W(DW), .NOP_PAYLOAD(NOP)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .up_valid_in    (up_valid_in),
    .up_ready_out   (up_ready_out),
    .up_data_in     (up_data_in),
    .down_valid_out (down_valid_out),
    .down_ready_in  (down_ready_in),
    .down_data_out  (down_data_out),
    .flush_in       (flush_in),
    .bubble_in      (bubble_in),
    .occupancy_out  (occupancy_out)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] src[$];
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  bit            last_up_fire;

  task automatic chk(input string tag, input logic [DW-1:0] got_v, input logic [DW-1:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  function automatic bit model_rdy(input bit dr, input bit bb);
`ifdef RV32_PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || (dr && !bb);
`endif
  endfunction

  task automatic cycle(input bit rst, input bit uv, input logic [DW-1:0] ud,
                       input bit dr, input bit fl, input bit bb);
    bit            e_rdy, e_vld, uf, df;
    logic [DW-1:0] e_dat;
    reset_in      = ~rst;
    up_valid_in   = uv;
    up_data_in    = ud;
    down_ready_in = dr;
    flush_in      = fl;
    bubble_in     = bb;
    @(negedge clk_in);
    e_rdy = model_rdy(dr, bb);
    e_vld = (mq.size() > 0) && !bb;
    e_dat = e_vld ? mq[0] : NOP;
    chk("up_ready", DW'(up_ready_out), DW'(e_rdy));
    chk("down_valid", DW'(down_valid_out), DW'(e_vld));
    chk("down_data", down_data_out, e_dat);
    chk("occupancy", DW'(occupancy_out), DW'(mq.size()));
`ifdef RV32_PIPE_SKID_EN
    down_ready_in = ~dr;
    #1;
    chk("rdy_indep", DW'(up_ready_out), DW'(e_rdy));
    down_ready_in = dr;
    #1;
`endif
    uf = uv && e_rdy;
    df = e_vld && dr;
    if (df && !rst && !fl) begin
      got.push_back(down_data_out);
      got_cyc.push_back(cyc);
    end
    @(posedge clk_in);
    if (rst || fl) begin
      mq.delete();
    end else begin
      if (df) void'(mq.pop_front());
      if (uf) mq.push_back(ud);
    end
    last_up_fire = uf && !rst;
    cyc++;
    #1;
  endtask

  task automatic step(input bit dr, input bit fl, input bit bb);
    bit            uv;
    logic [DW-1:0] ud;
    uv = (src.size() > 0);
    ud = uv ? src[0] : '0;
    cycle(1'b0, uv, ud, dr, fl, bb);
    if (last_up_fire) void'(src.pop_front());
  endtask

  initial begin
    logic [DW-1:0] exp_abc[3];
    reset_in      = 1'b0;
    up_valid_in   = 1'b1;
    up_data_in    = 160'hDEAD;
    down_ready_in = 1'b1;
    flush_in      = 1'b0;
    bubble_in     = 1'b0;
    @(posedge clk_in);
    #1;

    // Reset held with upstream valid, then first cycle after release
    cycle(1'b1, 1'b1, 160'hBEEF, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 160'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("rst_occ", DW'(occupancy_out), '0);
    chk("rst_rdy", DW'(up_ready_out), DW'(1));

    // Back-to-back streaming
    got.delete(); got_cyc.delete();
    for (int k = 1; k <= 8; k++) src.push_back(DW'(k));
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("stream_cnt", DW'(got.size()), DW'(8));
    for (int i = 0; i < got.size(); i++) chk("stream_ord", got[i], DW'(i + 1));
    for (int i = 1; i < got_cyc.size(); i++) chk("stream_gap", DW'(got_cyc[i] - got_cyc[i-1]), DW'(1));
    src.delete();

    // Stall then release
    got.delete();
    exp_abc[0] = 160'hA; exp_abc[1] = 160'hB; exp_abc[2] = 160'hC;
    for (int i = 0; i < 3; i++) src.push_back(exp_abc[i]);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    chk("stall_occ", DW'(occupancy_out), DW'(CAP));
    for (int i = 0; i < 12 && (src.size() > 0 || mq.size() > 0); i++) step(1'b1, 1'b0, 1'b0);
    chk("stall_cnt", DW'(got.size()), DW'(3));
    for (int i = 0; i < got.size() && i < 3; i++) chk("stall_ord", got[i], exp_abc[i]);
    src.delete();

    // Flush at full occupancy, then flush with a concurrent upstream transfer
    got.delete();
    for (int k = 0; k < 5; k++) src.push_back(DW'(160'hD0 + k));
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("flush_occ", DW'(occupancy_out), '0);
    chk("flush_vld", DW'(down_valid_out), '0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("flush2_occ", DW'(occupancy_out), '0);
    src.delete();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("flush_leak", DW'(got.size()), '0);

    // One-cycle bubble on a held head
    got.delete();
    cycle(1'b0, 1'b1, 160'h5, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("bubble_hold", DW'(got.size()), '0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bubble_cnt", DW'(got.size()), DW'(1));
    chk("bubble_dat", (got.size() > 0) ? got[0] : '1, 160'h5);

    // Random traffic
    repeat (10000) begin
      bit dr, fl, bb;
      if (src.size() == 0 && $urandom_range(0, 9) < 7)
        src.push_back({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      dr = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 99) < 3);
      bb = ($urandom_range(0, 9) == 0);
      step(dr, fl, bb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
